// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, FSM state type and index-width helper for the serial CLA adder
package cla_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cla_serial_word_adder_if.sv
// cla_serial_word_adder_if: operand/result handshake bundle; in_sub exists only with CLA_SERIAL_SUB_EN
interface cla_serial_word_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef CLA_SERIAL_SUB_EN
    logic             in_sub;
    modport master(output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                   input in_ready, out_valid, out_sum, out_cout);
    modport slave(input in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                  output in_ready, out_valid, out_sum, out_cout);
`else
    modport master(output in_valid, in_a, in_b, in_cin, out_ready,
                   input in_ready, out_valid, out_sum, out_cout);
    modport slave(input in_valid, in_a, in_b, in_cin, out_ready,
                  output in_ready, out_valid, out_sum, out_cout);
`endif
endinterface

// File: rtl/cla_nibble_slice.sv
// cla_nibble_slice: combinational 4-bit carry-lookahead adder, all carries computed directly from cin
module cla_nibble_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/cla_serial_word_adder.sv
// cla_serial_word_adder: WIDTH-bit adder using one CLA nibble slice per cycle; CLA_SERIAL_SUB_EN adds in_sub (A-B)
module cla_serial_word_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    cla_serial_word_adder_if.slave bus
);
    localparam int NIB = WIDTH / NIB_W;
    localparam int IW  = idx_w(NIB);
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             c_q, cout_q;
    logic [IW-1:0]    idx;
    logic [NIB_W-1:0] a_n, b_n, s_n;
    logic             s_co, last;
    assign a_n  = NIB_W'(a_q >> (idx * NIB_W));
    assign b_n  = NIB_W'(b_q >> (idx * NIB_W));
    assign last = idx == IW'(NIB - 1);
    cla_nibble_slice u_slice (
        .a   (a_n),
        .b   (b_n),
        .cin (c_q),
        .sum (s_n),
        .cout(s_co)
    );
    always_comb begin
        state_nx = (state == IDLE && bus.in_valid)  ? RUN  :
                   (state == RUN  && last)          ? DONE :
                   (state == DONE && bus.out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            idx    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.in_valid) begin
                a_q <= bus.in_a;
                idx <= '0;
`ifdef CLA_SERIAL_SUB_EN
                b_q <= bus.in_sub ? ~bus.in_b : bus.in_b;
                c_q <= bus.in_cin ^ bus.in_sub;
`else
                b_q <= bus.in_b;
                c_q <= bus.in_cin;
`endif
            end else if (state == RUN) begin
                for (int i = 0; i < NIB; i++)
                    if (idx == IW'(i)) sum_q[i*NIB_W +: NIB_W] <= s_n;
                c_q <= s_co;
                idx <= idx + 1'b1;
                if (last) cout_q <= s_co;
            end
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
endmodule
